bus_slave_ram: RTL and testbench
================================

# bus_slave_ram

System-bus responder that answers the transactions the CPU memory stage issues on the shared bus: it decodes a chip-select plus address strobe, applies a programmable number of wait states, then returns read data or commits write data with a single-cycle ready pulse. It backs a word-addressed on-chip RAM and occupies one slave slot behind the bus address decoder. It is the bench-reusable reference slave for bus-side integration of the memory stage.

## Interface
- WORD_DATA_WIDTH, 32, bus data width in bits
- WORD_ADDR_WIDTH, 30, bus word-address width
- MEM_ADDR_WIDTH, 10, internal RAM index width; depth = 2**MEM_ADDR_WIDTH words
- WAIT_CYCLES, 1, wait states inserted between acceptance and ready; legal range 0..15

- clk_i  input  1  single clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- bus_cs_i  input  1  slave select from the address decoder, active-high
- bus_as_i  input  1  address strobe, active-high; access requested when bus_cs_i && bus_as_i
- bus_rw_i  input  1  1 = read, 0 = write
- bus_addr_i  input  WORD_ADDR_WIDTH  word address
- bus_wr_data_i  input  WORD_DATA_WIDTH  write data
- bus_rd_data_o  output  WORD_DATA_WIDTH  read data; zero whenever bus_rdy_o is 0
- bus_rdy_o  output  1  one-cycle completion pulse
- busy_o  output  1  high while an access is in flight (WAIT or RESP)

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: when bus_cs_i && bus_as_i, latch addr[MEM_ADDR_WIDTH-1:0], rw, wr_data; go to WAIT with wait counter = WAIT_CYCLES, or directly to RESP if WAIT_CYCLES == 0. Otherwise stay.
- WAIT: decrement counter each cycle; on the cycle counter == 1, transition to RESP.
- RESP: bus_rdy_o = 1 for exactly one cycle. Read: bus_rd_data_o = RAM[latched index]. Write: RAM[latched index] written at the end of the RESP cycle; bus_rd_data_o = 0. Next state is always IDLE.
- Inputs are ignored in WAIT and RESP; the latched request is used. Deasserting bus_as_i mid-access does not abort.
- Address bits above MEM_ADDR_WIDTH are ignored (index wraps modulo depth).
- RAM read is synchronous: data read at the transition into RESP, so a read immediately following a write to the same index returns the new value.
- busy_o = (state != IDLE).

## Timing
- Reset: state IDLE, counter 0, bus_rdy_o 0, bus_rd_data_o 0, busy_o 0. RAM contents are not cleared.
- Request sampled at edge ending cycle T. bus_rdy_o high during cycle T+1+WAIT_CYCLES. Total latency request-to-ready = WAIT_CYCLES+1 cycles.
- After RESP, one IDLE cycle is mandatory; the next request is accepted at the earliest in the cycle following RESP. Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Reset asserted in WAIT or RESP: next state is IDLE, bus_rdy_o is 0 in the following cycle, and a pending write is not committed. A write whose RESP cycle coincides with reset is dropped.
- bus_cs_i high with bus_as_i low, or bus_as_i high with bus_cs_i low: no access.

## Test plan
- Reset, then read index 0 with WAIT_CYCLES=1 → bus_rdy_o pulses once 2 cycles after the request; busy_o high 2 cycles; data equals preloaded RAM[0].
- Write 0xDEADBEEF to addr 0x5, then read addr 0x5 in the first accepted cycle after RESP → read returns 0xDEADBEEF; bus_rd_data_o is 0 during the write RESP.
- WAIT_CYCLES=0, back-to-back reads of addr 1,2,3 with bus_as_i held high → bus_rdy_o pulses every 2 cycles, 3 pulses total, correct data each.
- Write 0x12345678 to addr 0x405 (MEM_ADDR_WIDTH=10) → read addr 0x005 returns 0x12345678 (wrap).
- WAIT_CYCLES=3, write 0xA5A5A5A5 to addr 7; assert rst_i in the 2nd WAIT cycle → no bus_rdy_o pulse; a subsequent read of addr 7 returns the old value.
- bus_as_i=1 with bus_cs_i=0 for 5 cycles → busy_o and bus_rdy_o stay 0; bus_rd_data_o stays 0.

Source files
------------

// File: rtl/bus_slave_ram.sv
// Bus slave in front of a word-addressed on-chip RAM: accepts one request at a
// time, counts WAIT_CYCLES wait states, then answers with a single-cycle ready.
module bus_slave_ram #(
  parameter int WORD_DATA_WIDTH = 32,
  parameter int WORD_ADDR_WIDTH = 30,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES     = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       bus_cs_i,
  input  logic                       bus_as_i,
  input  logic                       bus_rw_i,
  input  logic [WORD_ADDR_WIDTH-1:0] bus_addr_i,
  input  logic [WORD_DATA_WIDTH-1:0] bus_wr_data_i,
  output logic [WORD_DATA_WIDTH-1:0] bus_rd_data_o,
  output logic                       bus_rdy_o,
  output logic                       busy_o
);

  localparam int         MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [3:0]                  r_wait_cnt;
  logic [MEM_ADDR_WIDTH-1:0]   r_idx;
  logic                        r_rw;
  logic [WORD_DATA_WIDTH-1:0]  r_wr_data;
  logic [WORD_DATA_WIDTH-1:0]  r_ram_q;
  logic [WORD_DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

  logic                        w_req;
  logic [MEM_ADDR_WIDTH-1:0]   w_bus_idx;
  logic [MEM_ADDR_WIDTH-1:0]   w_rd_idx;
  logic                        w_commit_wr;
  logic                        w_unused_addr;

  assign w_req         = bus_cs_i && bus_as_i;
  assign w_bus_idx     = bus_addr_i[MEM_ADDR_WIDTH-1:0];
  assign w_unused_addr = ^bus_addr_i[WORD_ADDR_WIDTH-1:MEM_ADDR_WIDTH];

  // With zero wait states the RAM is read straight from the bus index on the
  // accepting edge; otherwise from the latched index on the edge leaving WAIT.
  assign w_rd_idx    = (r_state == S_IDLE) ? w_bus_idx : r_idx;
  assign w_commit_wr = (r_state == S_RESP) && !r_rw && !rst_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 4'd1) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus_rdy_o     = 1'b0;
    bus_rd_data_o = '0;
    busy_o        = (r_state != S_IDLE);
    if (r_state == S_RESP) begin
      bus_rdy_o = 1'b1;
      if (r_rw) begin
        bus_rd_data_o = r_ram_q;
      end
    end
  end

  // Request latch and wait counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= 4'd0;
      r_idx      <= '0;
      r_rw       <= 1'b0;
      r_wr_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_wait_cnt <= WAIT_INIT;
            r_idx      <= w_bus_idx;
            r_rw       <= bus_rw_i;
            r_wr_data  <= bus_wr_data_i;
          end
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        default: begin
          r_wait_cnt <= r_wait_cnt;
        end
      endcase
    end
  end

  // RAM: registered read every cycle, write committed at the end of RESP
  always_ff @(posedge clk_i) begin
    r_ram_q <= r_mem[w_rd_idx];
    if (w_commit_wr) begin
      r_mem[r_idx] <= r_wr_data;
    end
  end

endmodule

// File: tb/tb_bus_slave_ram.sv
// Directed bench: three slaves (1, 0 and 3 wait states) share the bus lines,
// each with its own chip select.
module tb_bus_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cs;
  logic        as;
  logic        rw;
  logic [29:0] addr;
  logic [31:0] wd;
  logic [2:0][31:0] rdata;
  logic [2:0]  rdy;
  logic [2:0]  busy;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rd;
  int          lat;
  int          pulses;

  always #5 clk = ~clk;

  bus_slave_ram #(.WAIT_CYCLES(1)) u_w1 (
    .clk_i(clk), .rst_i(rst), .bus_cs_i(cs[0]), .bus_as_i(as), .bus_rw_i(rw),
    .bus_addr_i(addr), .bus_wr_data_i(wd), .bus_rd_data_o(rdata[0]),
    .bus_rdy_o(rdy[0]), .busy_o(busy[0])
  );

  bus_slave_ram #(.WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst), .bus_cs_i(cs[1]), .bus_as_i(as), .bus_rw_i(rw),
    .bus_addr_i(addr), .bus_wr_data_i(wd), .bus_rd_data_o(rdata[1]),
    .bus_rdy_o(rdy[1]), .busy_o(busy[1])
  );

  bus_slave_ram #(.WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst), .bus_cs_i(cs[2]), .bus_as_i(as), .bus_rw_i(rw),
    .bus_addr_i(addr), .bus_wr_data_i(wd), .bus_rd_data_o(rdata[2]),
    .bus_rdy_o(rdy[2]), .busy_o(busy[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request pulse, then wait (bounded) for ready; returns after the RESP cycle.
  task automatic access(input int inst, input logic acc_rw, input logic [29:0] acc_addr,
                        input logic [31:0] acc_wd, output logic [31:0] acc_rd,
                        output int acc_lat);
    cs[inst] = 1'b1;
    as       = 1'b1;
    rw       = acc_rw;
    addr     = acc_addr;
    wd       = acc_wd;
    tick();
    cs       = 3'b000;
    as       = 1'b0;
    acc_lat  = 1;
    while (!rdy[inst] && acc_lat < 20) begin
      tick();
      acc_lat++;
    end
    if (!rdy[inst]) check("rdy timeout", {31'd0, rdy[inst]}, 32'd1);
    acc_rd = rdata[inst];
    $display("txn inst=%0d %s addr=%h wd=%h rd=%h lat=%0d", inst, acc_rw ? "RD" : "WR",
             acc_addr, acc_wd, acc_rd, acc_lat);
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    cs   = 3'b000;
    as   = 1'b0;
    rw   = 1'b0;
    addr = '0;
    wd   = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("reset rdy", {31'd0, rdy[i]}, 32'd0);
      check("reset busy", {31'd0, busy[i]}, 32'd0);
      check("reset rdata", rdata[i], 32'd0);
    end
    rst = 1'b0;
    tick();

    // Preload RAM[0], then reset: contents must survive
    access(0, 1'b0, 30'd0, 32'hCAFE0000, rd, lat);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Read index 0 with one wait state, cycle by cycle
    cs[0] = 1'b1; as = 1'b1; rw = 1'b1; addr = 30'd0;
    tick();
    cs = 3'b000; as = 1'b0;
    check("rd0 wait busy", {31'd0, busy[0]}, 32'd1);
    check("rd0 wait rdy", {31'd0, rdy[0]}, 32'd0);
    check("rd0 wait rdata", rdata[0], 32'd0);
    tick();
    check("rd0 resp busy", {31'd0, busy[0]}, 32'd1);
    check("rd0 resp rdy", {31'd0, rdy[0]}, 32'd1);
    check("rd0 resp rdata", rdata[0], 32'hCAFE0000);
    tick();
    check("rd0 after busy", {31'd0, busy[0]}, 32'd0);
    check("rd0 after rdy", {31'd0, rdy[0]}, 32'd0);
    $display("txn inst=0 RD addr=%h rd=%h (cycle-checked)", 30'd0, 32'hCAFE0000);

    // Write then immediate read of the same index
    access(0, 1'b0, 30'h5, 32'hDEADBEEF, rd, lat);
    check("wr5 resp rdata", rd, 32'd0);
    check("wr5 latency", lat, 32'd2);
    access(0, 1'b1, 30'h5, 32'd0, rd, lat);
    check("rd5 data", rd, 32'hDEADBEEF);
    check("rd5 latency", lat, 32'd2);

    // Upper address bits ignored
    access(0, 1'b0, 30'h405, 32'h12345678, rd, lat);
    access(0, 1'b1, 30'h005, 32'd0, rd, lat);
    check("wrap rd", rd, 32'h12345678);

    // Zero wait states: preload, then back-to-back reads with strobe held
    for (int k = 1; k <= 3; k++) begin
      access(1, 1'b0, 30'(k), 32'h10000000 + 32'(k), rd, lat);
      check("w0 wr latency", lat, 32'd1);
    end
    cs[1] = 1'b1; as = 1'b1; rw = 1'b1; addr = 30'd1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rdy[1]) pulses++;
      check("b2b rdy", {31'd0, rdy[1]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) begin
        check("b2b rdata", rdata[1], 32'h10000001 + 32'(i / 2));
        $display("txn inst=1 RD b2b rd=%h", rdata[1]);
      end
      if (i == 0) addr = 30'd2;
      if (i == 2) addr = 30'd3;
      if (i == 4) begin cs = 3'b000; as = 1'b0; end
    end
    check("b2b pulses", pulses, 32'd3);

    // Three wait states: reset during the second WAIT cycle drops the write
    access(2, 1'b0, 30'd7, 32'h11110007, rd, lat);
    check("w3 wr latency", lat, 32'd4);
    cs[2] = 1'b1; as = 1'b1; rw = 1'b0; addr = 30'd7; wd = 32'hA5A5A5A5;
    tick();
    cs = 3'b000; as = 1'b0;
    check("abort wait1 busy", {31'd0, busy[2]}, 32'd1);
    tick();
    check("abort wait2 busy", {31'd0, busy[2]}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort rst rdy", {31'd0, rdy[2]}, 32'd0);
    check("abort rst busy", {31'd0, busy[2]}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rdy[2]) pulses++;
    end
    check("abort no pulse", pulses, 32'd0);
    $display("txn inst=2 WR addr=%h wd=%h aborted by reset", 30'd7, 32'hA5A5A5A5);
    access(2, 1'b1, 30'd7, 32'd0, rd, lat);
    check("abort old data", rd, 32'h11110007);

    // Strobe without chip select: no access
    as = 1'b1; rw = 1'b1; addr = 30'd5; cs = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("nocs busy", {31'd0, busy[0]}, 32'd0);
      check("nocs rdy", {31'd0, rdy[0]}, 32'd0);
      check("nocs rdata", rdata[0], 32'd0);
    end
    as = 1'b0;
    $display("txn inst=0 strobe without select, 5 cycles");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
